deque_arbiter: RTL and testbench

DEQUE_ARBITER -- requirements
Module: deque_arbiter

---
 rtl/deque_arbiter_if.sv | 51 +++++
 rtl/deque_arbiter.sv | 147 ++++++++++++++
 tb/tb_deque_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/deque_arbiter_if.sv
// Requester command/response, deque control and deque status bundle for deque_arbiter.
// slave = arbiter side, master = requesters plus deque side.
interface deque_arbiter_if;
   logic       req0_valid;
   logic       req0_ready;
   logic       req0_pop;
   logic       req0_sel;
   logic [7:0] req0_data;
   logic       req1_valid;
   logic       req1_ready;
   logic       req1_pop;
   logic       req1_sel;
   logic [7:0] req1_data;

   logic       rsp0_valid;
   logic       rsp0_err;
   logic [7:0] rsp0_data;
   logic       rsp1_valid;
   logic       rsp1_err;
   logic [7:0] rsp1_data;

   logic       dq_select;
   logic       dq_push;
   logic       dq_pop;
   logic [7:0] dq_data_in;
   logic [7:0] dq_data_out;
   logic       dq_s0_empty;
   logic       dq_s0_full;
   logic       dq_s1_empty;
   logic       dq_s1_full;

   modport slave (
      input  req0_valid, req0_pop, req0_sel, req0_data,
      input  req1_valid, req1_pop, req1_sel, req1_data,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_err, rsp0_data,
      output rsp1_valid, rsp1_err, rsp1_data,
      output dq_select, dq_push, dq_pop, dq_data_in,
      input  dq_data_out, dq_s0_empty, dq_s0_full, dq_s1_empty, dq_s1_full
   );

   modport master (
      output req0_valid, req0_pop, req0_sel, req0_data,
      output req1_valid, req1_pop, req1_sel, req1_data,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_err, rsp0_data,
      input  rsp1_valid, rsp1_err, rsp1_data,
      input  dq_select, dq_push, dq_pop, dq_data_in,
      output dq_data_out, dq_s0_empty, dq_s0_full, dq_s1_empty, dq_s1_full
   );
endinterface

// File: rtl/deque_arbiter.sv
// Round-robin arbiter serialising two requesters' push/pop commands onto two deques (IDLE->ISSUE->CAPTURE).
// Define DEQUE_ARB_ERRCNT_EN to build the saturating rejected-command counter on err_count.
module deque_arbiter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   deque_arbiter_if.slave   bus,
   output logic [CNT_W-1:0] err_count
);
   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   state_t     state_q, state_d;
   logic       prio_q, prio_d;
   logic       id_q, id_d;
   logic       pop_q, pop_d;
   logic       sel_q, sel_d;
   logic       err_q, err_d;
   logic [7:0] data_q, data_d;

   logic       rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
   logic       rsp0_err_q, rsp0_err_d, rsp1_err_q, rsp1_err_d;
   logic [7:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;

   logic       gnt_vld, gnt_id, illegal, issue_ok;
   logic [7:0] rsp_byte;

   always_comb begin
      gnt_vld  = bus.req0_valid | bus.req1_valid;
      gnt_id   = (bus.req0_valid & bus.req1_valid) ? prio_q : bus.req1_valid;
      illegal  = pop_q ? (sel_q ? bus.dq_s1_empty : bus.dq_s0_empty)
                       : (sel_q ? bus.dq_s1_full  : bus.dq_s0_full);
      issue_ok = (state_q == ISSUE) && !illegal;
      rsp_byte = (pop_q && !err_q) ? bus.dq_data_out : 8'h00;
   end

   always_comb begin
      state_d        = state_q;
      prio_d         = prio_q;
      id_d           = id_q;
      pop_d          = pop_q;
      sel_d          = sel_q;
      err_d          = err_q;
      data_d         = data_q;
      rsp0_valid_d   = 1'b0;
      rsp1_valid_d   = 1'b0;
      rsp0_err_d     = 1'b0;
      rsp1_err_d     = 1'b0;
      rsp0_data_d    = 8'h00;
      rsp1_data_d    = 8'h00;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      case (state_q)
         IDLE: begin
            // ready is combinational, so it must also drop while rst is held
            if (gnt_vld && !rst) begin
               bus.req0_ready = !gnt_id;
               bus.req1_ready = gnt_id;
               id_d           = gnt_id;
               prio_d         = !gnt_id;
               pop_d          = gnt_id ? bus.req1_pop  : bus.req0_pop;
               sel_d          = gnt_id ? bus.req1_sel  : bus.req0_sel;
               data_d         = gnt_id ? bus.req1_data : bus.req0_data;
               state_d        = ISSUE;
            end
         end
         ISSUE: begin
            err_d   = illegal;
            state_d = CAPTURE;
         end
         CAPTURE: begin
            rsp0_valid_d = !id_q;
            rsp1_valid_d = id_q;
            rsp0_err_d   = !id_q & err_q;
            rsp1_err_d   = id_q & err_q;
            rsp0_data_d  = id_q ? 8'h00 : rsp_byte;
            rsp1_data_d  = id_q ? rsp_byte : 8'h00;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         prio_q       <= 1'b0;
         id_q         <= 1'b0;
         pop_q        <= 1'b0;
         sel_q        <= 1'b0;
         err_q        <= 1'b0;
         data_q       <= 8'h00;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_err_q   <= 1'b0;
         rsp1_err_q   <= 1'b0;
         rsp0_data_q  <= 8'h00;
         rsp1_data_q  <= 8'h00;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         id_q         <= id_d;
         pop_q        <= pop_d;
         sel_q        <= sel_d;
         err_q        <= err_d;
         data_q       <= data_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_err_q   <= rsp0_err_d;
         rsp1_err_q   <= rsp1_err_d;
         rsp0_data_q  <= rsp0_data_d;
         rsp1_data_q  <= rsp1_data_d;
      end
   end

   // Strobes, select and write data exist only in a legal ISSUE cycle
   assign bus.dq_push    = issue_ok & ~pop_q;
   assign bus.dq_pop     = issue_ok & pop_q;
   assign bus.dq_select  = issue_ok & sel_q;
   assign bus.dq_data_in = issue_ok ? data_q : 8'h00;

   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp0_err   = rsp0_err_q;
   assign bus.rsp1_err   = rsp1_err_q;
   assign bus.rsp0_data  = rsp0_data_q;
   assign bus.rsp1_data  = rsp1_data_q;

`ifdef DEQUE_ARB_ERRCNT_EN
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((state_q == CAPTURE) && err_q && (err_cnt_q != {CNT_W{1'b1}}))
         err_cnt_d = err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_cnt_q <= '0;
      else     err_cnt_q <= err_cnt_d;
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = '0;
`endif
endmodule

// File: tb/tb_deque_arbiter.sv
// Bench for deque_arbiter: behavioural 4-entry FIFO deques, command table, scoreboarded responses.
// Response expectations are queued at accept and popped when rspN_valid is seen.
module tb_deque_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] err_count;

   deque_arbiter_if bus();

   deque_arbiter #(.CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

`ifdef DEQUE_ARB_ERRCNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic       err;
      logic [7:0] data;
   } rsp_t;

   rsp_t sb0[$];
   rsp_t sb1[$];
   rsp_t exp0, exp1;
   logic [7:0] exp_cnt;

   // Behavioural deque pair: FIFO order, depth 4, read data registered on pop
   logic [7:0] mem0 [4];
   logic [7:0] mem1 [4];
   logic [1:0] head0 = 2'd0, head1 = 2'd0;
   logic [2:0] cnt0 = 3'd0, cnt1 = 3'd0;
   logic [1:0] wr0, wr1;

   assign wr0 = head0 + cnt0[1:0];
   assign wr1 = head1 + cnt1[1:0];
   assign bus.dq_s0_empty = (cnt0 == 3'd0);
   assign bus.dq_s0_full  = (cnt0 == 3'd4);
   assign bus.dq_s1_empty = (cnt1 == 3'd0);
   assign bus.dq_s1_full  = (cnt1 == 3'd4);

   initial bus.dq_data_out = 8'h00;

   always @(posedge clk) begin
      if (bus.dq_push) begin
         if (!bus.dq_select && cnt0 < 3'd4) begin
            mem0[wr0] <= bus.dq_data_in;
            cnt0      <= cnt0 + 3'd1;
         end else if (bus.dq_select && cnt1 < 3'd4) begin
            mem1[wr1] <= bus.dq_data_in;
            cnt1      <= cnt1 + 3'd1;
         end
      end
      if (bus.dq_pop) begin
         if (!bus.dq_select && cnt0 != 3'd0) begin
            bus.dq_data_out <= mem0[head0];
            head0           <= head0 + 2'd1;
            cnt0            <= cnt0 - 3'd1;
         end else if (bus.dq_select && cnt1 != 3'd0) begin
            bus.dq_data_out <= mem1[head1];
            head1           <= head1 + 2'd1;
            cnt1            <= cnt1 - 3'd1;
         end
      end
   end

   always @(negedge clk) begin
      if (bus.rsp0_valid) begin
         checks++;
         if (sb0.size() == 0) begin
            errors++;
            $display("FAIL rsp0_unexpected: got err=%0b data=%02h, required no response", bus.rsp0_err, bus.rsp0_data);
         end else begin
            exp0 = sb0.pop_front();
            if (bus.rsp0_err !== exp0.err || bus.rsp0_data !== exp0.data) begin
               errors++;
               $display("FAIL rsp0: got err=%0b data=%02h, required err=%0b data=%02h",
                        bus.rsp0_err, bus.rsp0_data, exp0.err, exp0.data);
            end
         end
      end
      if (bus.rsp1_valid) begin
         checks++;
         if (sb1.size() == 0) begin
            errors++;
            $display("FAIL rsp1_unexpected: got err=%0b data=%02h, required no response", bus.rsp1_err, bus.rsp1_data);
         end else begin
            exp1 = sb1.pop_front();
            if (bus.rsp1_err !== exp1.err || bus.rsp1_data !== exp1.data) begin
               errors++;
               $display("FAIL rsp1: got err=%0b data=%02h, required err=%0b data=%02h",
                        bus.rsp1_err, bus.rsp1_data, exp1.err, exp1.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h, required %02h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_ready0"},  8'(bus.req0_ready), 8'h00);
      chk({name, "_ready1"},  8'(bus.req1_ready), 8'h00);
      chk({name, "_push"},    8'(bus.dq_push),    8'h00);
      chk({name, "_pop"},     8'(bus.dq_pop),     8'h00);
      chk({name, "_select"},  8'(bus.dq_select),  8'h00);
      chk({name, "_din"},     bus.dq_data_in,     8'h00);
      chk({name, "_rsp0v"},   8'(bus.rsp0_valid), 8'h00);
      chk({name, "_rsp1v"},   8'(bus.rsp1_valid), 8'h00);
      chk({name, "_rsp0err"}, 8'(bus.rsp0_err),   8'h00);
      chk({name, "_rsp1err"}, 8'(bus.rsp1_err),   8'h00);
      chk({name, "_rsp0dat"}, bus.rsp0_data,      8'h00);
      chk({name, "_rsp1dat"}, bus.rsp1_data,      8'h00);
      chk({name, "_errcnt"},  err_count,          8'h00);
   endtask

   task automatic set_req(input bit id, input bit v, input bit pop, input bit sel, input logic [7:0] d);
      if (id) begin
         bus.req1_valid = v; bus.req1_pop = pop; bus.req1_sel = sel; bus.req1_data = d;
      end else begin
         bus.req0_valid = v; bus.req0_pop = pop; bus.req0_sel = sel; bus.req0_data = d;
      end
   endtask

   // Entered just after a negedge with the arbiter idle; returns at the negedge the response is visible
   task automatic do_cmd(input string name, input bit id, input bit pop, input bit sel,
                         input logic [7:0] d, input bit e_err, input logic [7:0] e_data);
      int w;
      rsp_t r;
      set_req(id, 1'b1, pop, sel, d);
      #1;
      w = 0;
      while (((id ? bus.req1_ready : bus.req0_ready) !== 1'b1) && w < 8) begin
         @(negedge clk); #1; w++;
      end
      chk({name, "_ready"},       8'(id ? bus.req1_ready : bus.req0_ready), 8'h01);
      chk({name, "_other_ready"}, 8'(id ? bus.req0_ready : bus.req1_ready), 8'h00);
      chk({name, "_wait"},        8'(w), 8'h00);
      r.err  = e_err;
      r.data = e_data;
      if (id) sb1.push_back(r); else sb0.push_back(r);
      @(negedge clk);
      set_req(id, 1'b0, 1'b0, 1'b0, 8'h00);
      #1;
      chk({name, "_issue_push"}, 8'(bus.dq_push),    8'(!e_err && !pop));
      chk({name, "_issue_pop"},  8'(bus.dq_pop),     8'(!e_err && pop));
      chk({name, "_issue_sel"},  8'(bus.dq_select),  8'(!e_err && sel));
      chk({name, "_issue_din"},  bus.dq_data_in,     e_err ? 8'h00 : d);
      chk({name, "_issue_rdy"},  8'(bus.req0_ready | bus.req1_ready), 8'h00);
      @(negedge clk);
      chk({name, "_cap_strobe"}, 8'(bus.dq_push | bus.dq_pop | bus.dq_select), 8'h00);
      chk({name, "_cap_din"},    bus.dq_data_in, 8'h00);
      @(negedge clk);
      if (e_err && CNT_EN && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      chk({name, "_errcnt"}, err_count, exp_cnt);
   endtask

   typedef struct {
      bit         id;
      bit         pop;
      bit         sel;
      logic [7:0] data;
      bit         err;
      logic [7:0] rdata;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int grants;
      bit exp_id;
      bit r0, r1;

      // id, pop, sel, data, expected err, expected response data
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 8'h00};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h3C};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'hA5};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 8'h00};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 8'h00};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 8'h00};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h11};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h22};

      exp_cnt = 8'h00;
      rst = 1'b1;
      set_req(1'b0, 1'b1, 1'b0, 1'b0, 8'h99);
      set_req(1'b1, 1'b1, 1'b0, 1'b0, 8'h98);
      #2;
      chk_all_zero("reset");
      @(negedge clk);
      set_req(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      set_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      rst = 1'b0;

      for (int i = 0; i < 13; i++)
         do_cmd($sformatf("v%0d", i), vecs[i].id, vecs[i].pop, vecs[i].sel,
                vecs[i].data, vecs[i].err, vecs[i].rdata);

      // Reset in the ISSUE cycle: strobe vanishes at once and no response follows
      set_req(1'b0, 1'b1, 1'b0, 1'b0, 8'h77);
      #1;
      chk("rstiss_ready", 8'(bus.req0_ready), 8'h01);
      @(negedge clk);
      set_req(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      set_req(1'b1, 1'b1, 1'b0, 1'b0, 8'h66);
      #1;
      chk("rstiss_push", 8'(bus.dq_push), 8'h01);
      #1;
      rst = 1'b1;
      #1;
      chk_all_zero("rstiss");
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 8'h00;

      // Both requesters held valid: grants alternate starting with requester 0
      set_req(1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
      set_req(1'b1, 1'b1, 1'b0, 1'b0, 8'h20);
      grants = 0;
      exp_id = 1'b0;
      for (int c = 0; c < 20 && grants < 4; c++) begin
         #1;
         r0 = bus.req0_ready;
         r1 = bus.req1_ready;
         chk($sformatf("rr_onehot_c%0d", c), 8'(r0 & r1), 8'h00);
         if (r0 || r1) begin
            chk($sformatf("rr_grant%0d", grants), 8'(r1), 8'(exp_id));
            if (r1) sb1.push_back(9'h000); else sb0.push_back(9'h000);
            exp_id = !exp_id;
            grants++;
         end
         @(negedge clk);
      end
      set_req(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      set_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("rr_grant_count", 8'(grants), 8'd4);
      repeat (3) @(negedge clk);
      chk("rr_errcnt", err_count, 8'h00);

      // Deque0 is now full: every push is rejected and the counter saturates
      for (int k = 0; k < 257; k++)
         do_cmd("sat", 1'b0, 1'b0, 1'b0, 8'hE0, 1'b1, 8'h00);
      chk("sat_final", err_count, CNT_EN ? 8'hFF : 8'h00);

      repeat (4) @(negedge clk);
      chk("sb0_drained", 8'(sb0.size()), 8'h00);
      chk("sb1_drained", 8'(sb1.size()), 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
